// File: rtl/m_div_iter_pkg.sv
// Shared encodings for the iterative divider: operation select and FSM states.
package m_div_iter_pkg;

    typedef enum logic [1:0] {
        SEL_DIV  = 2'b00,
        SEL_DIVU = 2'b01,
        SEL_REM  = 2'b10,
        SEL_REMU = 2'b11
    } sel_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    function automatic logic sel_signed(input logic [1:0] s);
        return (s == SEL_DIV) || (s == SEL_REM);
    endfunction

    function automatic logic sel_rem(input logic [1:0] s);
        return (s == SEL_REM) || (s == SEL_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep or restore, and emit one quotient bit.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_dvs,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_trial;

    // The partial remainder is always below the divisor, so the XLEN+1 bit
    // trial result fits and its MSB is a clean borrow flag.
    assign w_shift = {i_rem, i_quo[XLEN-1]};
    assign w_trial = w_shift - {1'b0, i_dvs};
    assign o_rem   = w_trial[XLEN] ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0];
    assign o_quo   = {i_quo[XLEN-2:0], ~w_trial[XLEN]};

endmodule

// File: rtl/m_div_iter.sv
// Iterative RISC-V style divider (DIV/DIVU/REM/REMU): magnitudes are divided
// one bit per cycle, then signs are fixed up; divide-by-zero and overflow short-cut.
module m_div_iter
    import m_div_iter_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [1:0]       sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  rd,
    output logic [TAG_W-1:0] out_tag
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [XLEN-1:0]    r_quo;
    logic [XLEN-1:0]    r_rem;
    logic [XLEN-1:0]    r_dvs;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_is_rem;
    logic               r_out_valid;
    logic [XLEN-1:0]    r_rd;
    logic [TAG_W-1:0]   r_out_tag;

    logic               w_signed;
    logic               w_is_rem;
    logic               w_neg1;
    logic               w_neg2;
    logic               w_div0;
    logic               w_ovf;
    logic [XLEN-1:0]    w_abs1;
    logic [XLEN-1:0]    w_abs2;
    logic [XLEN-1:0]    w_spec_rd;
    logic [XLEN-1:0]    w_fix_rd;
    logic [XLEN-1:0]    w_quo_nxt;
    logic [XLEN-1:0]    w_rem_nxt;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    assign w_signed  = sel_signed(sel);
    assign w_is_rem  = sel_rem(sel);
    assign w_neg1    = w_signed & rs1[XLEN-1];
    assign w_neg2    = w_signed & rs2[XLEN-1];
    assign w_abs1    = cond_neg(rs1, w_neg1);
    assign w_abs2    = cond_neg(rs2, w_neg2);
    assign w_div0    = (rs2 == '0);
    assign w_ovf     = w_signed && (rs1 == MIN_VAL) && (rs2 == '1);
    assign w_spec_rd = w_div0 ? (w_is_rem ? rs1 : '1) : (w_is_rem ? '0 : MIN_VAL);
    assign w_fix_rd  = r_is_rem ? cond_neg(r_rem, r_neg_r) : cond_neg(r_quo, r_neg_q);

    div_step #(.XLEN(XLEN)) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dvs (r_dvs),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_rd        <= '0;
            r_out_tag   <= '0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_out_tag <= in_tag;
                        r_is_rem  <= w_is_rem;
                        if (w_div0 || w_ovf) begin
                            r_rd        <= w_spec_rd;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_quo   <= w_abs1;
                            r_rem   <= '0;
                            r_dvs   <= w_abs2;
                            r_neg_q <= w_neg1 ^ w_neg2;
                            r_neg_r <= w_neg1;
                            r_cnt   <= '0;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_quo <= w_quo_nxt;
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(XLEN - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_rd        <= w_fix_rd;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign rd        = r_rd;
    assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_m_div_iter.sv
// Scoreboard bench for m_div_iter at XLEN=32 and XLEN=16 against an arithmetic reference.
module tb_m_div_iter;
    import m_div_iter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    bit done32   = 1'b0;
    bit done16   = 1'b0;

    // 32-bit instance signals
    logic        rst32 = 1'b1, flush32 = 1'b0, iv32 = 1'b0, or32 = 1'b1;
    logic        ir32, ov32;
    logic [31:0] a32 = '0, b32 = '0, rd32;
    logic [1:0]  sel32 = '0;
    logic [4:0]  tag32 = '0, ot32;

    // 16-bit instance signals
    logic        rst16 = 1'b1, flush16 = 1'b0, iv16 = 1'b0, or16 = 1'b1;
    logic        ir16, ov16;
    logic [15:0] a16 = '0, b16 = '0, rd16;
    logic [1:0]  sel16 = '0;
    logic [2:0]  tag16 = '0, ot16;

    m_div_iter #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst(rst32), .flush(flush32), .in_valid(iv32), .in_ready(ir32),
        .rs1(a32), .rs2(b32), .sel(sel32), .in_tag(tag32), .out_valid(ov32),
        .out_ready(or32), .rd(rd32), .out_tag(ot32)
    );

    m_div_iter #(.XLEN(16), .TAG_W(3)) dut16 (
        .clk(clk), .rst(rst16), .flush(flush16), .in_valid(iv16), .in_ready(ir16),
        .rs1(a16), .rs2(b16), .sel(sel16), .in_tag(tag16), .out_valid(ov16),
        .out_ready(or16), .rd(rd16), .out_tag(ot16)
    );

    typedef struct {
        logic [63:0] rd;
        logic [63:0] tag;
        int          lat;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // RISC-V division semantics computed with native 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] s, input logic [63:0] a_in,
                                          input logic [63:0] b_in, input int xl);
        logic [63:0] mask, a, b;
        longint      sa, sb;
        mask = (64'd1 << xl) - 64'd1;
        a = a_in & mask;
        b = b_in & mask;
        if (b == 64'd0) return s[1] ? a : mask;
        if (s[0] == 1'b0) begin
            sa = longint'(a);
            sb = longint'(b);
            if (a[xl-1]) sa = sa - longint'(64'd1 << xl);
            if (b[xl-1]) sb = sb - longint'(64'd1 << xl);
            return s[1] ? (64'(sa % sb) & mask) : (64'(sa / sb) & mask);
        end
        return s[1] ? (a % b) : (a / b);
    endfunction

    function automatic int exp_lat(input logic [1:0] s, input logic [63:0] a_in,
                                   input logic [63:0] b_in, input int xl);
        logic [63:0] mask;
        mask = (64'd1 << xl) - 64'd1;
        if ((b_in & mask) == 64'd0) return 1;
        if (!s[0] && (a_in & mask) == (64'd1 << (xl - 1)) && (b_in & mask) == mask) return 1;
        return xl + 2;
    endfunction

    function automatic logic [63:0] rnd_op(input int xl);
        logic [63:0] mask, r;
        mask = (64'd1 << xl) - 64'd1;
        case ($urandom_range(0, 5))
            0:       r = 64'd0;
            1:       r = 64'($urandom_range(1, 20));
            2:       r = mask;
            3:       r = 64'd1 << (xl - 1);
            default: r = {$urandom, $urandom} & mask;
        endcase
        return r;
    endfunction

    // Monitors: compare every cycle a result is presented, pop on handshake.
    int acc32 = 0, acc16 = 0;
    bit seen32 = 1'b0, seen16 = 1'b0;

    always @(negedge clk) begin
        if (rst32) begin
            seen32 = 1'b0;
        end else begin
            if (ov32) begin
                if (q32.size() == 0) begin
                    check("unexpected_valid32", 64'(ov32), 64'd0);
                end else begin
                    if (!seen32) begin
                        check("latency32", 64'(cyc - acc32 + 1), 64'(q32[0].lat));
                        seen32 = 1'b1;
                    end
                    check("rd32", 64'(rd32), q32[0].rd);
                    check("tag32", 64'(ot32), q32[0].tag);
                    if (or32 && !flush32) begin
                        void'(q32.pop_front());
                        seen32 = 1'b0;
                    end
                end
            end
            if (flush32) seen32 = 1'b0;
            if (iv32 && ir32 && !flush32) acc32 = cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (rst16) begin
            seen16 = 1'b0;
        end else begin
            if (ov16) begin
                if (q16.size() == 0) begin
                    check("unexpected_valid16", 64'(ov16), 64'd0);
                end else begin
                    if (!seen16) begin
                        check("latency16", 64'(cyc - acc16 + 1), 64'(q16[0].lat));
                        seen16 = 1'b1;
                    end
                    check("rd16", 64'(rd16), q16[0].rd);
                    check("tag16", 64'(ot16), q16[0].tag);
                    if (or16 && !flush16) begin
                        void'(q16.pop_front());
                        seen16 = 1'b0;
                    end
                end
            end
            if (iv16 && ir16 && !flush16) acc16 = cyc + 1;
        end
    end

    task automatic run32(input logic [1:0] s, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] tag, input int hold);
        int n;
        n = 0;
        while (!ir32 && n < 100) begin @(posedge clk); #1; n++; end
        if (!ir32) check("ready_timeout32", 64'(ir32), 64'd1);
        sel32 = s; a32 = a[31:0]; b32 = b[31:0]; tag32 = tag;
        iv32 = 1'b1; or32 = (hold == 0);
        q32.push_back('{model(s, a, b, 32), 64'(tag), exp_lat(s, a, b, 32)});
        @(posedge clk); #1;
        iv32 = 1'b0; a32 = $urandom; b32 = $urandom; tag32 = ~tag;
        n = 0;
        while (!ov32 && n < 200) begin @(posedge clk); #1; n++; end
        if (!ov32) begin
            check("valid_timeout32", 64'(ov32), 64'd1);
            q32.delete();
            return;
        end
        repeat (hold) begin
            check("in_ready_busy32", 64'(ir32), 64'd0);
            @(posedge clk); #1;
        end
        or32 = 1'b1;
        check("in_ready_hs32", 64'(ir32), 64'd0);
        @(posedge clk); #1;
        check("valid_drop32", 64'(ov32), 64'd0);
        check("in_ready_back32", 64'(ir32), 64'd1);
    endtask

    task automatic run16(input logic [1:0] s, input logic [63:0] a, input logic [63:0] b,
                         input logic [2:0] tag, input int hold);
        int n;
        n = 0;
        while (!ir16 && n < 100) begin @(posedge clk); #1; n++; end
        if (!ir16) check("ready_timeout16", 64'(ir16), 64'd1);
        sel16 = s; a16 = a[15:0]; b16 = b[15:0]; tag16 = tag;
        iv16 = 1'b1; or16 = (hold == 0);
        q16.push_back('{model(s, a, b, 16), 64'(tag), exp_lat(s, a, b, 16)});
        @(posedge clk); #1;
        iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); tag16 = ~tag;
        n = 0;
        while (!ov16 && n < 200) begin @(posedge clk); #1; n++; end
        if (!ov16) begin
            check("valid_timeout16", 64'(ov16), 64'd1);
            q16.delete();
            return;
        end
        repeat (hold) @(posedge clk);
        #1 or16 = 1'b1;
        @(posedge clk); #1;
        check("valid_drop16", 64'(ov16), 64'd0);
        check("in_ready_back16", 64'(ir16), 64'd1);
    endtask

    task automatic check_reset32(input string tag_name);
        check({tag_name, "_in_ready32"}, 64'(ir32), 64'd1);
        check({tag_name, "_out_valid32"}, 64'(ov32), 64'd0);
        check({tag_name, "_rd32"}, 64'(rd32), 64'd0);
        check({tag_name, "_out_tag32"}, 64'(ot32), 64'd0);
        check({tag_name, "_cnt32"}, 64'(dut32.r_cnt), 64'd0);
    endtask

    task automatic rstmid32();
        int n;
        n = 0;
        while (!ir32 && n < 100) begin @(posedge clk); #1; n++; end
        sel32 = 2'($urandom_range(0, 3));
        a32 = $urandom; b32 = ($urandom & 32'h7FFF_FFFF) | 32'd1; tag32 = 5'($urandom);
        iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        repeat ($urandom_range(2, 20)) @(posedge clk);
        #1 rst32 = 1'b1; flush32 = 1'b1;
        @(posedge clk); #1;
        rst32 = 1'b0; flush32 = 1'b0;
        check_reset32("rst_mid");
    endtask

    task automatic rstmid16();
        int n;
        n = 0;
        while (!ir16 && n < 100) begin @(posedge clk); #1; n++; end
        sel16 = 2'($urandom_range(0, 3));
        a16 = 16'($urandom); b16 = (16'($urandom) & 16'h7FFF) | 16'd1; tag16 = 3'($urandom);
        iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        repeat ($urandom_range(2, 12)) @(posedge clk);
        #1 rst16 = 1'b1;
        @(posedge clk); #1;
        rst16 = 1'b0;
        check("rst_mid_in_ready16", 64'(ir16), 64'd1);
        check("rst_mid_out_valid16", 64'(ov16), 64'd0);
        check("rst_mid_rd16", 64'(rd16), 64'd0);
        check("rst_mid_out_tag16", 64'(ot16), 64'd0);
    endtask

    // 32-bit directed cases followed by a random sweep.
    initial begin
        flush32 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst32 = 1'b0; flush32 = 1'b0;
        check_reset32("reset");

        run32(SEL_DIV,  64'hFFFF_FFF9, 64'd2, 5'd1, 0);
        run32(SEL_REM,  64'hFFFF_FFF9, 64'd2, 5'd2, 0);
        run32(SEL_DIVU, 64'hFFFF_FFFF, 64'd0, 5'd3, 0);
        run32(SEL_REMU, 64'hFFFF_FFFF, 64'd0, 5'd4, 2);
        run32(SEL_DIV,  64'h8000_0000, 64'hFFFF_FFFF, 5'd5, 0);
        run32(SEL_REM,  64'h8000_0000, 64'hFFFF_FFFF, 5'd6, 1);
        run32(SEL_REMU, 64'd100, 64'd7, 5'd7, 5);

        // flush in the middle of DIV 1000/3 while in_valid stays high
        sel32 = SEL_DIV; a32 = 32'd1000; b32 = 32'd3; tag32 = 5'd8; iv32 = 1'b1; or32 = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1 flush32 = 1'b1;
        @(posedge clk); #1;
        check("flush_idle32", 64'(ir32), 64'd1);
        check("flush_no_valid32", 64'(ov32), 64'd0);
        @(posedge clk); #1;
        check("flush_no_accept32", 64'(ir32), 64'd1);
        iv32 = 1'b0; flush32 = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("flush_quiet32", 64'(ov32), 64'd0);
        run32(SEL_DIVU, 64'd1000, 64'd3, 5'd9, 0);

        for (int i = 0; i < 40; i++) begin
            if (i % 10 == 9) rstmid32();
            else run32(2'($urandom_range(0, 3)), rnd_op(32), rnd_op(32), 5'($urandom),
                       $urandom_range(0, 3));
        end
        done32 = 1'b1;
    end

    // 16-bit random sweep running alongside.
    initial begin
        repeat (2) @(posedge clk);
        #1 rst16 = 1'b0;
        check("reset_in_ready16", 64'(ir16), 64'd1);
        check("reset_out_valid16", 64'(ov16), 64'd0);
        run16(SEL_DIV, 64'h8000, 64'hFFFF, 3'd1, 0);
        run16(SEL_REM, 64'hFFF9, 64'd2, 3'd2, 1);
        for (int i = 0; i < 40; i++) begin
            if (i % 10 == 7) rstmid16();
            else run16(2'($urandom_range(0, 3)), rnd_op(16), rnd_op(16), 3'($urandom),
                       $urandom_range(0, 2));
        end
        done16 = 1'b1;
    end

    initial begin
        int t;
        t = 0;
        while (!(done32 && done16) && t < 40000) begin @(posedge clk); t++; end
        if (!(done32 && done16)) check("global_timeout", 64'd0, 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
